// File: rtl/branch_predict_gshare_param_pkg.sv
// Shared types and constants for the gshare/bimodal branch predictor.
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned HASH_GSHARE  = 0;
  localparam int unsigned HASH_BIMODAL = 1;

endpackage

// File: rtl/branch_predict_gshare_param_sat_cnt.sv
// Saturating up/down counter step used for PHT updates.
module bp_sat_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] next
);

  always_comb begin
    next = cnt;
    if (up) begin
      if (cnt != '1) next = cnt + 1'b1;
    end else begin
      if (cnt != '0) next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predict_gshare_param.sv
// Parameterised gshare / bimodal direction predictor with an init walk over the PHT,
// speculative global history, checkpoint recovery and resolved/mispredict counters.
module branch_predict_gshare_param
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned GHR_LEN  = 8,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned HASH     = 0,
  parameter int unsigned INIT_CNT = 2 ** (CNT_W - 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallD,
  input  logic               flushD,
  input  logic [31:0]        pcF,
  input  logic               branchD,
  output logic               pred_takeF,
  output logic               pred_takeD,
  output logic [IDX_W-1:0]   pht_idxD,
  output logic [GHR_LEN-1:0] ghr_ckptD,
  input  logic               branchM,
  input  logic               actual_takeM,
  input  logic               pred_wrongM,
  input  logic [IDX_W-1:0]   pht_idxM,
  input  logic [GHR_LEN-1:0] ghr_ckptM,
  output logic               ready,
  output logic [31:0]        br_cnt,
  output logic [31:0]        mis_cnt
);

  localparam int unsigned Depth = 1 << IDX_W;

  bp_state_e          state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               ready_q;
  logic [GHR_LEN-1:0] ghr_q;
  logic               pred_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        br_cnt_q;
  logic [31:0]        mis_cnt_q;

  logic [CNT_W-1:0]   pht [Depth];

  // Fetch-side index and combinational prediction
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] fetch_idx;

  assign pc_idx = pcF[IDX_W+1:2];

  always_comb begin
    fetch_idx = pc_idx;
    if (HASH == HASH_GSHARE) fetch_idx = pc_idx ^ IDX_W'(ghr_q);
  end

  assign pred_takeF = ready_q & pht[fetch_idx][CNT_W-1];

  // Update path and single PHT write port
  logic [CNT_W-1:0] upd_cnt;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_data;

  bp_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .cnt  (pht[pht_idxM]),
    .up   (actual_takeM),
    .next (upd_cnt)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = CNT_W'(INIT_CNT);
    if (!rst) begin
      if (state_q == BP_INIT) begin
        wr_en = 1'b1;
      end else if (branchM) begin
        wr_en   = 1'b1;
        wr_idx  = pht_idxM;
        wr_data = upd_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

  // History candidates; the extra top bit falls off so GHR_LEN = 1 needs no special case
  logic [GHR_LEN:0] ghr_rec_full;
  logic [GHR_LEN:0] ghr_shift_full;

  assign ghr_rec_full   = {ghr_ckptM, actual_takeM};
  assign ghr_shift_full = {ghr_q, pred_takeD};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BP_INIT;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      unique case (state_q)
        BP_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_RUN: begin
          if (branchM && pred_wrongM) begin
            ghr_q <= ghr_rec_full[GHR_LEN-1:0];
          end else if (branchD && !stallD && !flushD) begin
            ghr_q <= ghr_shift_full[GHR_LEN-1:0];
          end
          if (branchM && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
          if (branchM && pred_wrongM && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
        end
        default: state_q <= BP_INIT;
      endcase
    end
  end

  // F->D pipeline register
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      pred_q <= 1'b0;
      idx_q  <= '0;
    end else if (!stallD) begin
      pred_q <= pred_takeF;
      idx_q  <= fetch_idx;
    end
  end

  assign pred_takeD = branchD & pred_q;
  assign pht_idxD   = idx_q;
  assign ghr_ckptD  = ghr_q;
  assign ready      = ready_q;
  assign br_cnt     = br_cnt_q;
  assign mis_cnt    = mis_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{pcF[31:IDX_W+2], pcF[1:0], ghr_rec_full[GHR_LEN],
                         ghr_shift_full[GHR_LEN]};

endmodule

// File: tb/tb_branch_predict_gshare_param.sv
// Directed bench: default gshare instance plus a bimodal IDX_W=10 / CNT_W=3 instance.
module tb_branch_predict_gshare_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_a, stall_a, flush_a, branchD_a, branchM_a, take_a, wrong_a;
  logic [31:0] pc_a;
  logic [7:0]  idxM_a, ckptM_a;
  logic        predF_a, predD_a, ready_a;
  logic [7:0]  idxD_a, ckptD_a;
  logic [31:0] br_a, mis_a;

  // Instance B: bimodal, 10-bit index, 3-bit counters
  logic        rst_b, stall_b, flush_b, branchD_b, branchM_b, take_b, wrong_b;
  logic [31:0] pc_b;
  logic [9:0]  idxM_b;
  logic [7:0]  ckptM_b;
  logic        predF_b, predD_b, ready_b;
  logic [9:0]  idxD_b;
  logic [7:0]  ckptD_b;
  logic [31:0] br_b, mis_b;

  branch_predict_gshare_param u_dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .stallD       (stall_a),
    .flushD       (flush_a),
    .pcF          (pc_a),
    .branchD      (branchD_a),
    .pred_takeF   (predF_a),
    .pred_takeD   (predD_a),
    .pht_idxD     (idxD_a),
    .ghr_ckptD    (ckptD_a),
    .branchM      (branchM_a),
    .actual_takeM (take_a),
    .pred_wrongM  (wrong_a),
    .pht_idxM     (idxM_a),
    .ghr_ckptM    (ckptM_a),
    .ready        (ready_a),
    .br_cnt       (br_a),
    .mis_cnt      (mis_a)
  );

  branch_predict_gshare_param #(
    .IDX_W (10),
    .CNT_W (3),
    .HASH  (1)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .stallD       (stall_b),
    .flushD       (flush_b),
    .pcF          (pc_b),
    .branchD      (branchD_b),
    .pred_takeF   (predF_b),
    .pred_takeD   (predD_b),
    .pht_idxD     (idxD_b),
    .ghr_ckptD    (ckptD_b),
    .branchM      (branchM_b),
    .actual_takeM (take_b),
    .pred_wrongM  (wrong_b),
    .pht_idxM     (idxM_b),
    .ghr_ckptM    (ckptM_b),
    .ready        (ready_b),
    .br_cnt       (br_b),
    .mis_cnt      (mis_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int cnt;

  initial begin
    {stall_a, flush_a, branchD_a, branchM_a, take_a, wrong_a} = '0;
    {stall_b, flush_b, branchD_b, branchM_b, take_b, wrong_b} = '0;
    pc_a = '0; idxM_a = '0; ckptM_a = '0;
    pc_b = '0; idxM_b = '0; ckptM_b = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    #1;
    check("rst_ready", ready_a, 0);
    check("rst_br_cnt", br_a, 0);
    check("rst_mis_cnt", mis_a, 0);
    check("rst_ghr", ckptD_a, 0);
    check("rst_idxD", idxD_a, 0);
    check("init_predF_zero", predF_a, 0);

    // Init walk length
    cnt = 0;
    while (!ready_a && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("init_len", cnt, 256);

    // Weakly taken everywhere after init
    pc_a = 32'h0000_0000; #1; check("predF_pc0", predF_a, 1);
    pc_a = 32'h0000_0014; #1; check("predF_pc14", predF_a, 1);
    pc_a = 32'h1234_5678; #1; check("predF_pc_misc", predF_a, 1);

    // PHT[5] decrements 2 -> 1 -> 0 -> 0
    pc_a = 32'h0000_0014;
    idxM_a = 8'h05; take_a = 1'b0; wrong_a = 1'b0; branchM_a = 1'b1;
    #1; check("same_cycle_read_old", predF_a, 1);
    @(negedge clk); check("dec1_visible_next", predF_a, 0);
    @(negedge clk);
    @(negedge clk);
    branchM_a = 1'b0;
    #1; check("dec3_not_taken", predF_a, 0);
    check("br_cnt_3", br_a, 3);
    // From floor 0: one increment leaves it not-taken, two make it taken
    take_a = 1'b1; branchM_a = 1'b1;
    @(negedge clk); check("inc_from_floor", predF_a, 0);
    @(negedge clk);
    branchM_a = 1'b0;
    #1; check("inc_twice_taken", predF_a, 1);
    check("br_cnt_5", br_a, 5);

    // Speculative history shifts up to 0x0F
    pc_a = 32'h0000_0040;
    @(negedge clk);
    check("idxD_load", idxD_a, 8'h10);
    branchD_a = 1'b1;
    #1; check("predD_taken", predD_a, 1);
    repeat (4) @(negedge clk);
    check("ghr_shift_0f", ckptD_a, 8'h0F);
    check("idxD_hashed", idxD_a, 8'h17);

    // Recovery beats the speculative shift in the same cycle
    branchM_a = 1'b1; wrong_a = 1'b1; ckptM_a = 8'hA0; take_a = 1'b1; idxM_a = 8'h30;
    @(negedge clk);
    branchM_a = 1'b0; wrong_a = 1'b0;
    check("ghr_recover", ckptD_a, 8'h41);
    check("mis_cnt_1", mis_a, 1);
    check("br_cnt_6", br_a, 6);
    check("idxD_pre_recover", idxD_a, 8'h1F);

    // Stall holds history and D index
    stall_a = 1'b1; pc_a = 32'h0000_0080;
    repeat (2) @(negedge clk);
    check("stall_ghr", ckptD_a, 8'h41);
    check("stall_idxD", idxD_a, 8'h1F);
    check("stall_predD", predD_a, 1);

    // Flush clears the F->D register and blocks the shift
    stall_a = 1'b0; flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    check("flush_predD", predD_a, 0);
    check("flush_idxD", idxD_a, 0);
    check("flush_ghr", ckptD_a, 8'h41);
    branchD_a = 1'b0;

    // Re-reset mid-init at ptr = 100
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    check("midinit_ready_low", ready_a, 0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("rerst_br_cnt", br_a, 0);
    check("rerst_mis_cnt", mis_a, 0);
    check("rerst_ghr", ckptD_a, 0);
    cnt = 0;
    while (!ready_a && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("reinit_len", cnt, 256);
    pc_a = 32'h0000_0014;
    #1; check("pht5_rewritten", predF_a, 1);

    // Instance B: bimodal index and 3-bit saturation
    cnt = 0;
    while (!ready_b && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    check("b_ready", ready_b, 1);
    pc_b = 32'h0000_0100;
    @(negedge clk);
    branchD_b = 1'b1;
    repeat (2) @(negedge clk);
    branchD_b = 1'b0;
    check("b_ghr", ckptD_b, 8'h03);
    check("b_idx_ignores_ghr", idxD_b, 10'h040);
    check("b_predF_init", predF_b, 1);
    idxM_b = 10'h040; take_b = 1'b1; branchM_b = 1'b1;
    repeat (6) @(negedge clk);
    take_b = 1'b0;
    repeat (3) @(negedge clk);
    branchM_b = 1'b0;
    #1; check("b_sat7_then_dec3", predF_b, 1);
    branchM_b = 1'b1;
    @(negedge clk);
    branchM_b = 1'b0;
    check("b_dec4_not_taken", predF_b, 0);
    check("b_br_cnt", br_b, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_gshare_param.md
BRANCH_PREDICT_GSHARE_PARAM -- requirements
Module: branch_predict_gshare_param

Interface
REQ-001 SHALL have parameter IDX_W, default 8, meaning PHT index width (PHT depth 2^IDX_W).
REQ-002 SHALL have parameter GHR_LEN, default 8, meaning global history length, legal range 1..IDX_W.
REQ-003 SHALL have parameter CNT_W, default 2, meaning saturating counter width, legal range 2..4.
REQ-004 SHALL have parameter HASH, default 0, meaning index mode (0 = gshare XOR, 1 = bimodal PC-only).
REQ-005 SHALL have parameter INIT_CNT, default 2^(CNT_W-1), meaning counter value written during init (weakly taken).
REQ-006 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stallD  in  1  D-stage stall.
- flushD  in  1  D-stage flush.
- pcF  in  32  fetch PC.
- branchD  in  1  D instruction is a conditional branch.
- pred_takeF  out  1  fetch-stage prediction.
- pred_takeD  out  1  registered prediction, gated by branchD.
- pht_idxD  out  IDX_W  PHT index used for the D instruction; pipeline carries it to M.
- ghr_ckptD  out  GHR_LEN  GHR before the D branch's speculative shift; pipeline carries it to M.
- branchM  in  1  M instruction is a conditional branch.
- actual_takeM  in  1  resolved direction.
- pred_wrongM  in  1  M branch was mispredicted.
- pht_idxM  in  IDX_W  carried index.
- ghr_ckptM  in  GHR_LEN  carried checkpoint.
- ready  out  1  PHT init complete.
- br_cnt  out  32  resolved-branch count.
- mis_cnt  out  32  mispredict count.

Function
REQ-007 SHALL implement a two-state FSM, INIT and RUN; rst enters INIT with init pointer 0.
REQ-008 In INIT, the block SHALL write INIT_CNT to PHT[ptr] once per cycle and increment ptr; after writing entry 2^IDX_W-1 it SHALL enter RUN on the next cycle; ready = 1 only in RUN.
REQ-009 While ready = 0: pred_takeF = 0, PHT updates ignored, GHR held at 0, counters held.
REQ-010 Fetch index SHALL be pcF[IDX_W+1:2] XOR {zero-extended GHR} when HASH = 0, or pcF[IDX_W+1:2] when HASH = 1.
REQ-011 pred_takeF SHALL equal the MSB of PHT[fetch index] (combinational read).
REQ-012 On a clock edge with rst or flushD, the F->D register SHALL load pred = 0 and idx = 0; otherwise it SHALL load pred_takeF and the fetch index when ~stallD, and hold when stallD.
REQ-013 pred_takeD = branchD & registered pred; pht_idxD = registered idx; ghr_ckptD = current GHR (combinational).
REQ-014 GHR recovery SHALL have highest priority: if branchM & pred_wrongM, GHR <= {ghr_ckptM[GHR_LEN-2:0], actual_takeM}; when GHR_LEN = 1, GHR <= actual_takeM.
REQ-015 Else if branchD & ~stallD & ~flushD, GHR <= {GHR[GHR_LEN-2:0], pred_takeD}; else GHR holds.
REQ-016 When branchM & ready, PHT[pht_idxM] SHALL saturate-increment if actual_takeM and saturate-decrement otherwise.
- Bounds are 0 and 2^CNT_W-1.
- Same-cycle read and write of the same entry: the read returns the pre-update value.
REQ-017 br_cnt SHALL increment on each branchM in RUN; mis_cnt SHALL increment on each branchM & pred_wrongM in RUN; both saturate at 0xFFFF_FFFF.
REQ-018 Update latency: a PHT write is visible to pred_takeF on the cycle after branchM.

Reset
REQ-019 On rst the block SHALL set: state = INIT, ptr = 0, GHR = 0, F->D register = 0, br_cnt = 0, mis_cnt = 0, ready = 0.
REQ-020 rst asserted during INIT or RUN SHALL restart init from entry 0; PHT contents are rewritten, not relied upon.
REQ-021 The block SHALL use no asynchronous reset, and the PHT SHALL have no reset port (cleared by the INIT walk only).

Structure
REQ-022 Package bp_pkg SHALL hold the FSM state enum (BP_INIT, BP_RUN) and the HASH_GSHARE = 0 / HASH_BIMODAL = 1 constants.
REQ-023 Sub-module bp_sat_cnt (CNT_W; in: cnt, up; out: next) SHALL implement the saturating update.
REQ-024 The PHT SHALL be a single 2^IDX_W x CNT_W array with one combinational read port and one write port; the write mux selects the init write in INIT and the update write in RUN.

Verification
REQ-025 Default parameters, rst for 1 cycle -> ready = 0 for exactly 256 cycles, then 1; pred_takeF = 1 for any pcF.
REQ-026 branchM with pht_idxM = 0x05, actual_takeM = 0, applied three times -> PHT[5] goes 2 -> 1 -> 0 -> 0; pred_takeF = 0 at pcF = 0x14 with GHR = 0.
REQ-027 GHR = 0x0F, branchD with pred_takeD = 1 and branchM & pred_wrongM with ghr_ckptM = 0xA0, actual_takeM = 1 in the same cycle -> GHR = 0x41 (recovery wins).
REQ-028 stallD = 1 with branchD = 1 -> GHR and pht_idxD unchanged; flushD -> pred_takeD = 0 on the next cycle.
REQ-029 rst asserted at init ptr = 100 -> ready low for a further 256 cycles; br_cnt = mis_cnt = 0.
REQ-030 HASH = 1, IDX_W = 10, CNT_W = 3 -> index ignores GHR; the counter saturates at 7 after 6 taken updates from init 4.
